// File: rtl/avalon_pio_arb_pkg.sv
// Shared types for the round-robin Avalon PIO arbiter: FSM state encoding and pointer sizing.
package avalon_pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int PTR_W       = $clog2(NUM_REQ_DEF);

  // A one-requester configuration would otherwise give a zero-width pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker, zero latency: first set request strictly after ptr, wrapping.
// No backpressure of its own; the caller decides when the grant is taken.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // i == N lands back on ptr itself, so the last winner is considered last.
    for (int i = 1; i <= N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/avalon_pio_arbiter.sv
// Round-robin master sharing one zero-wait Avalon PIO slave; valid in cycle N -> bus cycle N+1 -> rsp N+2.
// Requesters stall on req_valid until their one-cycle req_ready pulse; one access per two cycles.
module avalon_pio_arbiter
  import avalon_pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_readdata,
  output logic [ADDR_W-1:0]           avm_address,
  output logic                        avm_chipselect,
  output logic                        avm_write_n,
  output logic [DATA_W-1:0]           avm_writedata,
  input  logic [DATA_W-1:0]           avm_readdata
);

  localparam int PW = ptr_width(NUM_REQ);

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [PW-1:0]       gidx;
  logic                gany;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // The registered avm_* outputs double as the command latch, and req_ready
  // remembers the winner so rsp_valid can be a one-cycle-delayed copy of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ptr            <= PW'(NUM_REQ - 1);
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_readdata   <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
    end else begin
      req_ready      <= '0;
      rsp_valid      <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      case (state)
        IDLE, RESP: begin
          if (gany) begin
            state          <= ACCESS;
            ptr            <= gidx;
            req_ready      <= grant;
            avm_chipselect <= 1'b1;
            avm_write_n    <= ~req_write[gidx];
            avm_address    <= req_address[int'(gidx)*ADDR_W +: ADDR_W];
            avm_writedata  <= req_writedata[int'(gidx)*DATA_W +: DATA_W];
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state        <= RESP;
          rsp_valid    <= req_ready;
          rsp_readdata <= avm_write_n ? avm_readdata : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_pio_arbiter.sv
// Directed bench for avalon_pio_arbiter with a PIO-like slave: out_port at address 0, other addresses read 0.
module tb_avalon_pio_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [7:0]   req_address;
  logic [127:0] req_writedata;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_readdata;
  logic [1:0]   avm_address;
  logic         avm_chipselect;
  logic         avm_write_n;
  logic [31:0]  avm_writedata;
  logic [31:0]  avm_readdata;
  logic [31:0]  out_port;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  avalon_pio_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_writedata  (req_writedata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_readdata   (rsp_readdata),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata)
  );

  assign avm_readdata = (avm_address == 2'd0) ? out_port : 32'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= 32'd0;
    else if (avm_chipselect && !avm_write_n && avm_address == 2'd0) out_port <= avm_writedata;
  end

  typedef struct {
    int          idx;
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [31:0] exp_port;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int i, input bit wr, input logic [1:0] a, input logic [31:0] d);
    req_write[i]            = wr;
    req_address[i*2 +: 2]   = a;
    req_writedata[i*32 +: 32] = d;
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) if (oh[k]) r = k;
    return r;
  endfunction

  task automatic do_single(input vec_t v, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << v.idx;
    @(negedge clk);
    set_cmd(v.idx, v.wr, v.addr, v.data);
    req_valid[v.idx] = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d ready", n), {28'd0, req_ready}, {28'd0, oh});
    check($sformatf("v%0d cs", n), {31'd0, avm_chipselect}, 32'd1);
    check($sformatf("v%0d write_n", n), {31'd0, avm_write_n}, {31'd0, ~v.wr});
    check($sformatf("v%0d addr", n), {30'd0, avm_address}, {30'd0, v.addr});
    check($sformatf("v%0d wdata", n), avm_writedata, v.data);
    req_valid[v.idx] = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d rsp_valid", n), {28'd0, rsp_valid}, {28'd0, oh});
    check($sformatf("v%0d rdata", n), rsp_readdata, v.exp_rd);
    check($sformatf("v%0d cs_resp", n), {31'd0, avm_chipselect}, 32'd0);
    check($sformatf("v%0d ready_resp", n), {28'd0, req_ready}, 32'd0);
    check($sformatf("v%0d out_port", n), out_port, v.exp_port);
    @(negedge clk);
    check($sformatf("v%0d rsp_idle", n), {28'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int   g[$];
    int   gcyc[$];
    logic prev_cs;
    vec_t v3;

    vecs[0] = '{idx: 1, wr: 1'b1, addr: 2'd0, data: 32'hDEADBEEF, exp_rd: 32'h0,        exp_port: 32'hDEADBEEF};
    vecs[1] = '{idx: 2, wr: 1'b0, addr: 2'd0, data: 32'h0,        exp_rd: 32'hDEADBEEF, exp_port: 32'hDEADBEEF};
    vecs[2] = '{idx: 2, wr: 1'b0, addr: 2'd1, data: 32'h0,        exp_rd: 32'h0,        exp_port: 32'hDEADBEEF};
    vecs[3] = '{idx: 3, wr: 1'b1, addr: 2'd0, data: 32'h12345678, exp_rd: 32'h0,        exp_port: 32'h12345678};
    vecs[4] = '{idx: 0, wr: 1'b0, addr: 2'd0, data: 32'h0,        exp_rd: 32'h12345678, exp_port: 32'h12345678};
    vecs[5] = '{idx: 3, wr: 1'b1, addr: 2'd2, data: 32'hAAAA5555, exp_rd: 32'h0,        exp_port: 32'h12345678};
    vecs[6] = '{idx: 1, wr: 1'b0, addr: 2'd0, data: 32'h0,        exp_rd: 32'h12345678, exp_port: 32'h12345678};

    // Reset with random inputs
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid     = 4'($urandom);
      req_write     = 4'($urandom);
      req_address   = 8'($urandom);
      req_writedata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("rst cs", {31'd0, avm_chipselect}, 32'd0);
      check("rst write_n", {31'd0, avm_write_n}, 32'd1);
      check("rst ready", {28'd0, req_ready}, 32'd0);
      check("rst rsp_valid", {28'd0, rsp_valid}, 32'd0);
      check("rst rdata", rsp_readdata, 32'd0);
      check("rst addr", {30'd0, avm_address}, 32'd0);
    end
    @(negedge clk);
    req_valid = '0; req_write = '0; req_address = '0; req_writedata = '0;
    reset_n = 1'b1;

    for (int n = 0; n < 7; n++) do_single(vecs[n], n);

    // Round robin from a fresh pointer: every requester writes its own id
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b1, 2'd0, 32'(i));
    req_valid = 4'hF;
    prev_cs = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("rr cs_consec c%0d", c), {31'd0, avm_chipselect & prev_cs}, 32'd0);
      check($sformatf("rr rsp_onehot c%0d", c), {31'd0, $onehot0(rsp_valid)}, 32'd1);
      prev_cs = avm_chipselect;
      if (req_ready != 4'd0) begin
        g.push_back(oh2idx(req_ready));
        gcyc.push_back(c);
        if (g.size() == 6) req_valid = '0;
      end
    end
    req_valid = '0;
    check("rr grant_count", 32'(g.size()), 32'd6);
    for (int k = 0; k < g.size() && k < 6; k++) begin
      check($sformatf("rr grant%0d", k), 32'(g[k]), 32'(k % 4));
      if (k > 0) check($sformatf("rr spacing%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd2);
    end
    @(negedge clk);
    check("rr out_port", out_port, 32'd1);

    // Pointer wrap: grant req3, then req0 and req2 contend
    v3 = '{idx: 3, wr: 1'b1, addr: 2'd1, data: 32'h33, exp_rd: 32'h0, exp_port: 32'd1};
    do_single(v3, 7);
    @(negedge clk);
    set_cmd(0, 1'b0, 2'd0, 32'h0);
    set_cmd(2, 1'b0, 2'd0, 32'h0);
    req_valid = 4'b0101;
    g.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) begin
        g.push_back(oh2idx(req_ready));
        req_valid = req_valid & ~req_ready;
      end
    end
    req_valid = '0;
    check("wrap grant_count", 32'(g.size()), 32'd2);
    if (g.size() >= 2) begin
      check("wrap first", 32'(g[0]), 32'd0);
      check("wrap second", 32'(g[1]), 32'd2);
    end

    // Reset during the bus cycle: no response, pointer back to its reset value
    @(negedge clk);
    set_cmd(1, 1'b1, 2'd0, 32'hCAFEF00D);
    req_valid = 4'b0010;
    @(negedge clk);
    check("abort cs_before", {31'd0, avm_chipselect}, 32'd1);
    check("abort ready_before", {28'd0, req_ready}, 32'h2);
    reset_n = 1'b0;
    req_valid = '0;
    #1;
    check("abort cs", {31'd0, avm_chipselect}, 32'd0);
    check("abort write_n", {31'd0, avm_write_n}, 32'd1);
    check("abort ready", {28'd0, req_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort rsp c%0d", c), {28'd0, rsp_valid}, 32'd0);
    end
    reset_n = 1'b1;
    set_cmd(0, 1'b1, 2'd0, 32'hA0);
    set_cmd(3, 1'b1, 2'd0, 32'hA3);
    req_valid = 4'b1001;
    @(negedge clk);
    check("post_rst first", {28'd0, req_ready}, 32'h1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("post_rst rsp0", {28'd0, rsp_valid}, 32'h1);
    check("post_rst out_port", out_port, 32'hA0);
    @(negedge clk);
    check("post_rst second", {28'd0, req_ready}, 32'h8);
    req_valid = '0;
    @(negedge clk);
    check("post_rst rsp3", {28'd0, rsp_valid}, 32'h8);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
